// File: rtl/exe_issue_arbiter_if.sv
// Issue bus between the reservation stations and the EXE-stage issue arbiter.
// Request side : Req_Valid_IN, Req_Long_IN, Req_HiLoWr_IN, Req_HiLoRd_IN, Req_Tag_IN
// Response side: Grant_OUT (combinational), Issue_Valid_OUT, Issue_Sel_OUT,
//                Issue_Tag_OUT, Busy_OUT (registered)
// master = reservation-station side, slave = arbiter side.
interface exe_issue_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 6
);
  logic [NUM_REQ-1:0]       Req_Valid_IN;
  logic [NUM_REQ-1:0]       Req_Long_IN;
  logic [NUM_REQ-1:0]       Req_HiLoWr_IN;
  logic [NUM_REQ-1:0]       Req_HiLoRd_IN;
  logic [NUM_REQ*TAG_W-1:0] Req_Tag_IN;
  logic [NUM_REQ-1:0]       Grant_OUT;
  logic                     Issue_Valid_OUT;
  logic [2:0]               Issue_Sel_OUT;
  logic [TAG_W-1:0]         Issue_Tag_OUT;
  logic                     Busy_OUT;

  modport master (
    output Req_Valid_IN, Req_Long_IN, Req_HiLoWr_IN, Req_HiLoRd_IN, Req_Tag_IN,
    input  Grant_OUT, Issue_Valid_OUT, Issue_Sel_OUT, Issue_Tag_OUT, Busy_OUT
  );

  modport slave (
    input  Req_Valid_IN, Req_Long_IN, Req_HiLoWr_IN, Req_HiLoRd_IN, Req_Tag_IN,
    output Grant_OUT, Issue_Valid_OUT, Issue_Sel_OUT, Issue_Tag_OUT, Busy_OUT
  );
endinterface

// File: rtl/exe_issue_arbiter.sv
// Round-robin arbiter sharing the single EXE-stage ALU between NUM_REQ
// reservation stations. Holds off issue while a long op (MULT/DIV) occupies
// the ALU and interlocks HI/LO readers behind an in-flight HI/LO writer.
// Ports:
//   CLK, RESET (async, active-low)
//   STALL_fMEM : freeze EXE input registers
//   Flush_IN   : synchronous squash, wins over STALL_fMEM
//   bus        : exe_issue_arbiter_if.slave (requests in, grant/issue out)
//   Perf_Grants_OUT, Perf_StallCyc_OUT : only with EXE_ARB_PERF_EN defined
// Optional feature macro: EXE_ARB_PERF_EN (grant/stall counters + grant trace).
module exe_issue_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned TAG_W    = 6,
  parameter int unsigned LONG_LAT = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                STALL_fMEM,
  input  logic                Flush_IN,
  exe_issue_arbiter_if.slave  bus
`ifdef EXE_ARB_PERF_EN
  ,
  output logic [31:0]         Perf_Grants_OUT,
  output logic [31:0]         Perf_StallCyc_OUT
`endif
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(LONG_LAT + 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]   r_busy_cnt;
  logic               r_hilo_block;
  logic               r_issue_valid;
  logic [2:0]         r_issue_sel;
  logic [TAG_W-1:0]   r_issue_tag;
  logic               r_busy;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_grant_en;
  logic [PTR_W-1:0]   w_winner;
  logic               w_found;
  logic [PTR_W:0]     w_idx;
  logic [PTR_W-1:0]   w_ptr_next;
  logic [TAG_W-1:0]   w_win_tag;

  // HI/LO readers are masked while a writer is still in flight.
  assign w_elig = bus.Req_Valid_IN & ~(bus.Req_HiLoRd_IN & {NUM_REQ{r_hilo_block}});

  // RESET is folded in so no grant escapes while the arbiter is held in reset.
  assign w_grant_en = RESET && (r_state == ST_IDLE) && !STALL_fMEM && !Flush_IN && (|w_elig);

  // Rotating priority scan starting at r_rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_idx >= (PTR_W+1)'(NUM_REQ)) w_idx = w_idx - (PTR_W+1)'(NUM_REQ);
      if (!w_found && w_elig[w_idx[PTR_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[PTR_W-1:0];
      end
    end
  end

  assign w_ptr_next = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + PTR_W'(1);
  assign w_win_tag  = bus.Req_Tag_IN[w_winner*TAG_W +: TAG_W];

  assign bus.Grant_OUT       = w_grant_en ? (NUM_REQ'(1) << w_winner) : '0;
  assign bus.Issue_Valid_OUT = r_issue_valid;
  assign bus.Issue_Sel_OUT   = r_issue_sel;
  assign bus.Issue_Tag_OUT   = r_issue_tag;
  assign bus.Busy_OUT        = r_busy;

  // Issue FSM: IDLE grants; BUSY counts down the long-op occupancy.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_busy_cnt    <= '0;
      r_hilo_block  <= 1'b0;
      r_issue_valid <= 1'b0;
      r_issue_sel   <= '0;
      r_issue_tag   <= '0;
      r_busy        <= 1'b0;
    end else if (Flush_IN) begin
      r_state       <= ST_IDLE;
      r_busy_cnt    <= '0;
      r_hilo_block  <= 1'b0;
      r_issue_valid <= 1'b0;
      r_busy        <= 1'b0;
    end else if (!STALL_fMEM) begin
      case (r_state)
        ST_IDLE: begin
          // Any block still set here came from a short writer: it lasts one edge.
          r_hilo_block <= w_grant_en && bus.Req_HiLoWr_IN[w_winner];
          if (w_grant_en) begin
            r_issue_valid <= 1'b1;
            r_issue_sel   <= 3'(w_winner);
            r_issue_tag   <= w_win_tag;
            r_rr_ptr      <= w_ptr_next;
            if (bus.Req_Long_IN[w_winner]) begin
              r_state    <= ST_BUSY;
              r_busy_cnt <= CNT_W'(LONG_LAT - 1);
              r_busy     <= 1'b1;
            end
          end else begin
            r_issue_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          r_issue_valid <= 1'b0;
          if (r_busy_cnt == CNT_W'(1)) begin
            r_state      <= ST_IDLE;
            r_busy_cnt   <= '0;
            r_busy       <= 1'b0;
            r_hilo_block <= 1'b0;
          end else begin
            r_busy_cnt <= r_busy_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef EXE_ARB_PERF_EN
  // Free-running counters; flush does not touch them.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Perf_Grants_OUT   <= '0;
      Perf_StallCyc_OUT <= '0;
    end else begin
      if (w_grant_en) begin
        Perf_Grants_OUT <= Perf_Grants_OUT + 32'd1;
        $display("exe_issue_arbiter grant idx=%0d tag=0x%0h", w_winner, w_win_tag);
      end
      if ((|bus.Req_Valid_IN) && !w_grant_en) Perf_StallCyc_OUT <= Perf_StallCyc_OUT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exe_issue_arbiter.sv
module tb_exe_issue_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int TAG_W    = 6;
  localparam int LONG_LAT = 4;

  logic CLK;
  logic RESET;
  logic STALL_fMEM;
  logic Flush_IN;

  exe_issue_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

`ifdef EXE_ARB_PERF_EN
  logic [31:0] perf_grants;
  logic [31:0] perf_stall;
`endif

  exe_issue_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .LONG_LAT(LONG_LAT)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .STALL_fMEM (STALL_fMEM),
    .Flush_IN   (Flush_IN),
    .bus        (bus)
`ifdef EXE_ARB_PERF_EN
    ,
    .Perf_Grants_OUT   (perf_grants),
    .Perf_StallCyc_OUT (perf_stall)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: remaining ALU occupancy in cycles, pointer, HI/LO block, issue regs.
  int          m_ptr;
  int          m_busy_left;
  bit          m_hilo;
  bit          m_iv;
  int          m_sel;
  logic [5:0]  m_tag;

  localparam logic [23:0] TAGS = {6'h33, 6'h22, 6'h11, 6'h15};

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ptr = 0; m_busy_left = 0; m_hilo = 0; m_iv = 0; m_sel = 0; m_tag = '0;
  endtask

  function automatic int m_winner(input logic [3:0] v, input logic [3:0] rd, input bit st, input bit fl);
    if (m_busy_left > 0 || st || fl) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NUM_REQ;
      if (v[idx] && !(rd[idx] && m_hilo)) return idx;
    end
    return -1;
  endfunction

  // One clock: drive, check combinational grant and registered outputs, advance model.
  task automatic step(input logic [3:0] v, input logic [3:0] lg, input logic [3:0] wr,
                      input logic [3:0] rd, input bit st, input bit fl, input logic [23:0] tg);
    int w;
    logic [3:0] eg;
    bus.Req_Valid_IN  = v;
    bus.Req_Long_IN   = lg;
    bus.Req_HiLoWr_IN = wr;
    bus.Req_HiLoRd_IN = rd;
    bus.Req_Tag_IN    = tg;
    STALL_fMEM        = st;
    Flush_IN          = fl;
    #1;
    w  = m_winner(v, rd, st, fl);
    eg = (w < 0) ? 4'b0000 : 4'(1 << w);
    chk("grant",       32'(bus.Grant_OUT),       32'(eg));
    chk("issue_valid", 32'(bus.Issue_Valid_OUT), 32'(m_iv));
    chk("issue_sel",   32'(bus.Issue_Sel_OUT),   32'(m_sel));
    chk("issue_tag",   32'(bus.Issue_Tag_OUT),   32'(m_tag));
    chk("busy",        32'(bus.Busy_OUT),        32'(m_busy_left > 0));
    @(posedge CLK);
    if (fl) begin
      m_iv = 0; m_busy_left = 0; m_hilo = 0;
    end else if (!st) begin
      if (m_busy_left > 0) begin
        m_iv = 0;
        m_busy_left--;
        if (m_busy_left == 0) m_hilo = 0;
      end else if (w >= 0) begin
        m_iv  = 1;
        m_sel = w;
        m_tag = tg[w*TAG_W +: TAG_W];
        m_ptr = (w + 1) % NUM_REQ;
        m_hilo = wr[w];
        if (lg[w]) m_busy_left = LONG_LAT - 1;
      end else begin
        m_iv = 0; m_hilo = 0;
      end
    end
    #1;
  endtask

  initial begin
    // Reset held with all requesters valid.
    RESET = 1'b0; STALL_fMEM = 0; Flush_IN = 0;
    bus.Req_Valid_IN = 4'b1111; bus.Req_Long_IN = '0; bus.Req_HiLoWr_IN = '0;
    bus.Req_HiLoRd_IN = '0; bus.Req_Tag_IN = TAGS;
    m_reset();
    #3;
    chk("rst_grant",  32'(bus.Grant_OUT),       32'h0);
    chk("rst_valid",  32'(bus.Issue_Valid_OUT), 32'h0);
    chk("rst_sel",    32'(bus.Issue_Sel_OUT),   32'h0);
    chk("rst_tag",    32'(bus.Issue_Tag_OUT),   32'h0);
    chk("rst_busy",   32'(bus.Busy_OUT),        32'h0);
    @(posedge CLK); @(posedge CLK); #1;
    RESET = 1'b1;

    // Round-robin across all four short requesters, including the wrap.
    for (int i = 0; i < 5; i++) step(4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0, TAGS);
    chk("rr_last_sel", 32'(bus.Issue_Sel_OUT), 32'd0);
    chk("rr_last_tag", 32'(bus.Issue_Tag_OUT), 32'h15);

    // Long op from requester 1 blocks requester 2 for LONG_LAT-1 cycles.
    step(4'b0110, 4'b0010, 4'b0000, 4'b0000, 0, 0, TAGS);
    chk("long_busy", 32'(bus.Busy_OUT), 32'd1);
    for (int i = 0; i < LONG_LAT - 1; i++) step(4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 0, TAGS);
    chk("long_done", 32'(bus.Busy_OUT), 32'd0);
    step(4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 0, TAGS);
    chk("long_next_sel", 32'(bus.Issue_Sel_OUT), 32'd2);

    // HI/LO interlock behind a long writer on requester 0.
    step(4'b0001, 4'b0001, 4'b0001, 4'b0000, 0, 0, TAGS);
    for (int i = 0; i < LONG_LAT - 1; i++) step(4'b1100, 4'b0000, 4'b0000, 4'b1000, 0, 0, TAGS);
    step(4'b1000, 4'b0000, 4'b0000, 4'b1000, 0, 0, TAGS);
    chk("hilo_rd_sel", 32'(bus.Issue_Sel_OUT), 32'd3);

    // Stall freezes the issue registers and the pointer.
    step(4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, TAGS);
    for (int i = 0; i < 3; i++) step(4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 0, TAGS);
    chk("stall_tag",   32'(bus.Issue_Tag_OUT),   32'h15);
    chk("stall_valid", 32'(bus.Issue_Valid_OUT), 32'd1);
    step(4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0, TAGS);
    chk("stall_ptr_sel", 32'(bus.Issue_Sel_OUT), 32'd1);

    // Flush during BUSY with stall asserted, then a HI/LO reader goes through.
    step(4'b0001, 4'b0001, 4'b0001, 4'b0000, 0, 0, TAGS);
    step(4'b1000, 4'b0000, 4'b0000, 4'b1000, 1, 1, TAGS);
    chk("flush_busy",  32'(bus.Busy_OUT),        32'd0);
    chk("flush_valid", 32'(bus.Issue_Valid_OUT), 32'd0);
    step(4'b1000, 4'b0000, 4'b0000, 4'b1000, 0, 0, TAGS);
    chk("flush_rd_sel", 32'(bus.Issue_Sel_OUT), 32'd3);

    // Asynchronous reset in the middle of a long op.
    step(4'b0010, 4'b0010, 4'b0000, 4'b0000, 0, 0, TAGS);
    RESET = 1'b0;
    #1;
    chk("arst_busy",  32'(bus.Busy_OUT),        32'd0);
    chk("arst_valid", 32'(bus.Issue_Valid_OUT), 32'd0);
    chk("arst_grant", 32'(bus.Grant_OUT),       32'd0);
    m_reset();
    @(posedge CLK); #1;
    RESET = 1'b1;
    step(4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0, TAGS);
    chk("arst_first_sel", 32'(bus.Issue_Sel_OUT), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] v, lg, wr, rd;
      v  = 4'($urandom);
      lg = 4'($urandom) & 4'($urandom);
      wr = 4'($urandom) & 4'($urandom);
      rd = 4'($urandom) & 4'($urandom);
      step(v, lg, wr, rd, ($urandom_range(7) == 0), ($urandom_range(15) == 0), 24'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
